// File: rtl/mem_loader.sv
// ----------------------------------------------------------------------------
// mem_loader
//
// Host-side load/run/dump sequencer for the single-cycle core.
//   1. LOAD      : accept LOAD_LEN bytes on the in_* valid/ready stream and
//                  write them to data_mem starting at LOAD_BASE while the
//                  core is held in reset.
//   2. RUN       : release the core and wait for cpu_done, aborting after
//                  TIMEOUT cycles (sticky timeout flag, no dump).
//   3. DUMP_RD/  : read DUMP_LEN bytes from data_mem starting at DUMP_BASE
//      DUMP_WAIT   and stream them out on the out_* valid/ready stream.
//   4. FIN       : report completion; a new start re-runs the sequence.
// All data_mem address arithmetic wraps modulo 2^ADDR_W.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a sequence (sampled in IDLE and FIN only)
//   in_valid   in   load byte valid
//   in_data    in   load byte
//   in_ready   out  load byte accepted this cycle (high throughout LOAD)
//   mem_own    out  loader owns the data_mem port (LOAD, DUMP_RD, DUMP_WAIT)
//   mem_addr   out  data_mem address
//   mem_wdata  out  data_mem write data
//   mem_wen    out  data_mem write enable
//   mem_ren    out  data_mem read enable
//   mem_rdata  in   data_mem read data, combinational from mem_addr
//   cpu_reset  out  active-high core reset, low only in RUN
//   cpu_done   in   core done/halt
//   out_valid  out  dump byte valid
//   out_data   out  dump byte
//   out_ready  in   dump consumer ready
//   busy       out  state is neither IDLE nor FIN
//   finished   out  state is FIN
//   timeout    out  sticky RUN abort flag, cleared when FIN is left
// ----------------------------------------------------------------------------
module mem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned LOAD_LEN  = 64,
    parameter int unsigned DUMP_BASE = 64,
    parameter int unsigned DUMP_LEN  = 32,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_own,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_reset,
    input  logic              cpu_done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              finished,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_WAIT,
        S_FIN
    } state_t;

    // Terminal counts; only meaningful when the matching length is non-zero.
    localparam logic [15:0]       LOAD_LAST   = 16'(LOAD_LEN - 1);
    localparam logic [15:0]       DUMP_LAST   = 16'(DUMP_LEN - 1);
    localparam logic [15:0]       RUN_LAST    = 16'(TIMEOUT - 1);
    localparam bit                HAS_LOAD    = (LOAD_LEN != 0);
    localparam bit                HAS_DUMP    = (DUMP_LEN != 0);
    localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] DUMP_BASE_A = ADDR_W'(DUMP_BASE);

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         cyc_q, cyc_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                timeout_q, timeout_d;

    logic [ADDR_W-1:0]   load_addr;
    logic [ADDR_W-1:0]   dump_addr;

    // Byte counter truncated to the address width gives modulo wrap for free.
    assign load_addr = LOAD_BASE_A + ADDR_W'(cnt_q);
    assign dump_addr = DUMP_BASE_A + ADDR_W'(cnt_q);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cyc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            timeout_q   <= timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        timeout_d   = timeout_q;

        unique case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    // Leaving FIN always clears the sticky abort flag.
                    timeout_d = 1'b0;
                    if (HAS_LOAD) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RUN;
                        cyc_d   = '0;
                    end
                end
            end

            S_LOAD: begin
                // in_ready is constantly high here, so in_valid is the handshake.
                if (in_valid) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LOAD_LAST) begin
                        state_d = S_RUN;
                        cyc_d   = '0;
                    end
                end
            end

            S_RUN: begin
                cyc_d = cyc_q + 16'd1;
                // cpu_done takes priority over the final timeout cycle.
                if (cpu_done) begin
                    if (HAS_DUMP) begin
                        state_d = S_DUMP_RD;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_FIN;
                    end
                end else if (cyc_q == RUN_LAST) begin
                    state_d   = S_FIN;
                    timeout_d = 1'b1;
                end
            end

            S_DUMP_RD: begin
                out_data_d  = mem_rdata;
                out_valid_d = 1'b1;
                state_d     = S_DUMP_WAIT;
            end

            S_DUMP_WAIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + 16'd1;
                    state_d     = (cnt_q == DUMP_LAST) ? S_FIN : S_DUMP_RD;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Memory port and stream outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        mem_own   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                in_ready  = 1'b1;
                mem_own   = 1'b1;
                mem_addr  = load_addr;
                mem_wdata = in_data;
                mem_wen   = in_valid;
            end
            S_DUMP_RD: begin
                mem_own  = 1'b1;
                mem_ren  = 1'b1;
                mem_addr = dump_addr;
            end
            S_DUMP_WAIT: begin
                // Keep ownership and a stable address while the byte waits.
                mem_own  = 1'b1;
                mem_addr = dump_addr;
            end
            default: begin
            end
        endcase
    end

    // Decoded from state so the async reset reasserts cpu_reset immediately.
    assign cpu_reset = (state_q != S_RUN);
    assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    assign finished  = (state_q == S_FIN);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign timeout   = timeout_q;

endmodule
